seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner.sv | 166 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for an 8-digit common-anode display.
// Each digit slot presents one BCD code to the downstream 7-segment decoder and
// drives the matching active-low anode. A packed display word is accepted over a
// valid/ready handshake into a shadow buffer and copied to the active buffer only
// when the digit index wraps, so a frame never shows a mix of old and new digits.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to replace leading zero digits
// (above the most significant nonzero digit, never digit 0) with the blank code
// 4'hF and clear their decimal points when a word moves to the active buffer.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous reset, active low
//   load_valid   producer offers a new display word
//   load_ready   block can accept a word (no word pending)
//   digits_in    packed BCD, digit k = digits_in[4k+3:4k], digit 0 rightmost
//   dp_in        decimal-point request per digit, active high
//   display_en   0 forces all anodes off; scanning continues
//   bcd_out      BCD code for the current slot (registered)
//   an_out       anodes, active low (registered)
//   dp_out       decimal-point cathode, active low (registered)
//   frame_start  one-cycle pulse in the first cycle of slot 0 (registered)
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      display_en,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      dp_out,
    output logic                      frame_start
);

    localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0]      shd_dig_q, shd_dig_d;
    logic [NUM_DIGITS-1:0]           shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0][3:0]      act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]           act_dp_q, act_dp_d;
    logic [3:0]                      bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]           an_q, an_d;
    logic                            dp_q, dp_d;
    logic                            fs_q, fs_d;

    logic [NUM_DIGITS-1:0][3:0]      xfer_dig;
    logic [NUM_DIGITS-1:0]           xfer_dp;
    logic                            cnt_last;
    logic                            idx_last;
    logic                            wrap;

    // Shadow contents as they will appear in the active buffer after transfer.
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        xfer_dig = shd_dig_q;
        xfer_dp  = shd_dp_q;
        lead     = 1'b1;
        // Walk down from the top digit; blank while still in the leading-zero run.
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            if (lead && (shd_dig_q[k] == 4'h0)) begin
                xfer_dig[k] = 4'hF;
                xfer_dp[k]  = 1'b0;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        xfer_dig = shd_dig_q;
        xfer_dp  = shd_dp_q;
    end
`endif

    assign cnt_last = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
    assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign wrap     = cnt_last & idx_last;

    // Next-state: scan counters, handshake/transfer, registered outputs.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        shd_dig_d = shd_dig_q;
        shd_dp_d  = shd_dp_q;
        act_dig_d = act_dig_q;
        act_dp_d  = act_dp_q;
        bcd_d     = bcd_q;
        an_d      = '1;
        dp_d      = dp_q;
        fs_d      = 1'b0;

        if (cnt_last) begin
            cnt_d = '0;
            idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Accept needs pending = 0 and transfer needs pending = 1, so they never collide.
        if (load_valid && !pending_q) begin
            shd_dig_d = digits_in;
            shd_dp_d  = dp_in;
            pending_d = 1'b1;
        end else if (wrap && pending_q) begin
            act_dig_d = xfer_dig;
            act_dp_d  = xfer_dp;
            pending_d = 1'b0;
        end

        // Registered one cycle behind (idx, cnt); pulse lands on cnt == 0, idx == 0.
        fs_d  = wrap;
        bcd_d = act_dig_q[idx_q];
        dp_d  = ~act_dp_q[idx_q];
        if (display_en && (cnt_q >= CNT_W'(BLANK_CYCLES))) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            shd_dig_q <= {NUM_DIGITS{4'hF}};
            shd_dp_q  <= '0;
            act_dig_q <= {NUM_DIGITS{4'hF}};
            act_dp_q  <= '0;
            bcd_q     <= 4'hF;
            an_q      <= '1;
            dp_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shd_dig_q <= shd_dig_d;
            shd_dp_q  <= shd_dp_d;
            act_dig_q <= act_dig_d;
            act_dp_q  <= act_dp_d;
            bcd_q     <= bcd_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
            fs_q      <= fs_d;
        end
    end

    assign load_ready  = ~pending_q;
    assign bcd_out     = bcd_q;
    assign an_out      = an_q;
    assign dp_out      = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed test of seven_seg_scanner with 4-cycle slots,
// 1 blank cycle per slot and 8 digits (32-cycle frame). Time t counts clock
// edges since reset release; registered outputs at t reflect the scan state at t-1.
module tb_seven_seg_scanner;

    localparam int unsigned ND = 8;
    localparam int unsigned DC = 4;
    localparam int unsigned BC = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_valid;
    logic          load_ready;
    logic [31:0]   digits_in;
    logic [7:0]    dp_in;
    logic          display_en;
    logic [3:0]    bcd_out;
    logic [7:0]    an_out;
    logic          dp_out;
    logic          frame_start;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .display_en (display_en),
        .bcd_out    (bcd_out),
        .an_out     (an_out),
        .dp_out     (dp_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @t=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    // Anode pattern for an idle scan with display enabled, at time t >= 1.
    function automatic logic [7:0] exp_an(input int t);
        int c;
        int i;
        logic [7:0] one;
        c = (t - 1) % DC;
        i = ((t - 1) / DC) % ND;
        one = 8'h01;
        if (c == 0) return 8'hFF;
        return ~(one << i);
    endfunction

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        digits_in  = 32'h0;
        dp_in      = 8'h0;
        display_en = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        cyc = 0;

        // Reset values
        chk("rst_an",    32'(an_out),      32'hFF);
        chk("rst_bcd",   32'(bcd_out),     32'hF);
        chk("rst_dp",    32'(dp_out),      32'h1);
        chk("rst_fs",    32'(frame_start), 32'h0);
        chk("rst_ready", 32'(load_ready),  32'h1);

        // Idle scan: blank digits, walking anode, frame_start every 32 cycles
        for (int t = 1; t <= 40; t++) begin
            tick();
            chk("idle_bcd", 32'(bcd_out),     32'hF);
            chk("idle_an",  32'(an_out),      32'(exp_an(t)));
            chk("idle_fs",  32'(frame_start), (t % 32 == 0) ? 32'h1 : 32'h0);
        end

        // Load a word mid-frame (t=40 is slot 2 of frame 1)
        digits_in  = 32'h1234_5678;
        dp_in      = 8'h04;
        load_valid = 1'b1;
        tick();                                   // t=41, accepted
        chk("acc1_ready", 32'(load_ready), 32'h0);
        // Second word held while pending
        digits_in  = 32'h8765_4321;
        dp_in      = 8'h00;
        run_to(60);
        chk("old_bcd",    32'(bcd_out),    32'hF);
        chk("pend_ready", 32'(load_ready), 32'h0);
        run_to(63);
        chk("pre_xfer_ready", 32'(load_ready), 32'h0);
        tick();                                   // t=64, transfer happened
        chk("xfer_ready", 32'(load_ready), 32'h1);
        chk("xfer_fs",    32'(frame_start), 32'h1);
        tick();                                   // t=65, second word accepted
        chk("acc2_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
        tick();                                   // t=66
        chk("w1_s0_bcd", 32'(bcd_out), 32'h8);
        chk("w1_s0_an",  32'(an_out),  32'hFE);
        chk("w1_s0_dp",  32'(dp_out),  32'h1);
        run_to(74);
        chk("w1_s2_bcd", 32'(bcd_out), 32'h6);
        chk("w1_s2_an",  32'(an_out),  32'hFB);
        chk("w1_s2_dp",  32'(dp_out),  32'h0);
        run_to(95);
        chk("w1_s7_bcd", 32'(bcd_out), 32'h1);
        run_to(98);
        chk("w2_s0_bcd", 32'(bcd_out), 32'h1);
        chk("w2_s0_an",  32'(an_out),  32'hFE);
        chk("w2_ready",  32'(load_ready), 32'h1);
        run_to(106);
        chk("w2_s2_bcd", 32'(bcd_out), 32'h3);
        chk("w2_s2_dp",  32'(dp_out),  32'h1);

        // Display disabled for a full frame
        run_to(128);
        display_en = 1'b0;
        for (int t = 129; t <= 160; t++) begin
            tick();
            chk("dis_an", 32'(an_out), 32'hFF);
            chk("dis_fs", 32'(frame_start), (t == 160) ? 32'h1 : 32'h0);
            if (t == 130) chk("dis_bcd_s0", 32'(bcd_out), 32'h1);
            if (t == 138) chk("dis_bcd_s2", 32'(bcd_out), 32'h3);
        end
        display_en = 1'b1;

        // Pending word discarded by reset in slot 5
        digits_in  = 32'h9999_9999;
        dp_in      = 8'hFF;
        load_valid = 1'b1;
        tick();                                   // t=161, accepted
        chk("acc3_ready", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
        tick();                                   // t=162
        chk("en_back_an", 32'(an_out), 32'hFE);
        run_to(181);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_an",    32'(an_out),     32'hFF);
        chk("mid_rst_bcd",   32'(bcd_out),    32'hF);
        chk("mid_rst_dp",    32'(dp_out),     32'h1);
        chk("mid_rst_ready", 32'(load_ready), 32'h1);
        reset_n = 1'b1;
        cyc = 0;
        run_to(34);
        chk("disc_bcd_s0", 32'(bcd_out), 32'hF);
        chk("disc_an_s0",  32'(an_out),  32'hFE);
        run_to(38);
        chk("disc_bcd_s1", 32'(bcd_out), 32'hF);
        chk("disc_dp_s1",  32'(dp_out),  32'h1);

        // Leading-zero handling (blanked only with LEADING_ZERO_BLANK_EN)
        run_to(40);
        digits_in  = 32'h0000_0420;
        dp_in      = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] eb;
            logic       ed;
`ifdef LEADING_ZERO_BLANK_EN
            case (k)
                0:       begin eb = 4'h0; ed = 1'b0; end
                1:       begin eb = 4'h2; ed = 1'b0; end
                2:       begin eb = 4'h4; ed = 1'b0; end
                default: begin eb = 4'hF; ed = 1'b1; end
            endcase
`else
            case (k)
                1:       eb = 4'h2;
                2:       eb = 4'h4;
                default: eb = 4'h0;
            endcase
            ed = 1'b0;
`endif
            run_to(64 + 4 * k + 2);
            chk("lz420_bcd", 32'(bcd_out), 32'(eb));
            chk("lz420_dp",  32'(dp_out),  32'(ed));
        end
        run_to(90);
        digits_in  = 32'h0000_0000;
        dp_in      = 8'h00;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] eb;
`ifdef LEADING_ZERO_BLANK_EN
            eb = (k == 0) ? 4'h0 : 4'hF;
`else
            eb = 4'h0;
`endif
            run_to(96 + 4 * k + 2);
            chk("lz0_bcd", 32'(bcd_out), 32'(eb));
            chk("lz0_dp",  32'(dp_out),  32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
